// File: rtl/mil_line_director.sv
// mil_line_director
//   Half-duplex direction controller for MIL-STD-1553 terminals with
//   redundant bus lines. It produces the bit-rate io_clk and decides whether
//   the lines listen or one line talks. Exactly one transmitter is enabled per
//   packet, followed by a programmable turnaround back to receive. A watchdog
//   bounds the transmit time, and each line has packet start/end strobes.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   ch_sel        requested transmit line, sampled on RECEIVE->TRANSMIT
//   rcv_busy      per-line receiver busy
//   tr_busy       transmitter is shifting a word
//   tr_request    transmit data pending
//   rcv_enable    per-line receiver enable
//   tr_enable     one-hot transmitter enable
//   io_clk        bit-rate clock to the transceivers
//   packet_start  1-clk pulse on a rise of rcv_busy[i]
//   packet_end    1-clk pulse on a fall of rcv_busy[i]
//   tr_abort      1-clk pulse when the transmit watchdog fires
//   active_ch     line latched for the current/last transmit
//   state         0=RECEIVE, 1=TRANSMIT, 2=WAIT
module mil_line_director #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned IOCLK_DIV  = 50,
  parameter int unsigned T2R_DELAY  = 12,
  parameter int unsigned TR_TIMEOUT = 800,
  parameter int unsigned CNTR_W     = 10,
  localparam int unsigned CW        = $clog2(CHANNELS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       ch_sel,
  input  logic [CHANNELS-1:0] rcv_busy,
  input  logic                tr_busy,
  input  logic                tr_request,
  output logic [CHANNELS-1:0] rcv_enable,
  output logic [CHANNELS-1:0] tr_enable,
  output logic                io_clk,
  output logic [CHANNELS-1:0] packet_start,
  output logic [CHANNELS-1:0] packet_end,
  output logic                tr_abort,
  output logic [CW-1:0]       active_ch,
  output logic [1:0]          state
);

  localparam int unsigned DIV_W = (IOCLK_DIV > 1) ? $clog2(IOCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(IOCLK_DIV - 1);
  localparam logic [CNTR_W-1:0] T2R_CNT     = CNTR_W'(T2R_DELAY);
  localparam logic [CNTR_W-1:0] TIMEOUT_CNT = CNTR_W'(TR_TIMEOUT);
  localparam logic [CW-1:0]     CH_LIMIT    = CW'(CHANNELS);
  localparam logic              WD_ENABLED  = (TR_TIMEOUT != 0);

  typedef enum logic [1:0] {
    RECEIVE  = 2'd0,
    TRANSMIT = 2'd1,
    WAIT     = 2'd2
  } stateT;

  stateT               stateQ;
  logic [DIV_W-1:0]    divCnt;
  logic                ioClkQ;
  logic                ioUp;
  logic [CNTR_W-1:0]   cnt;
  logic [CW-1:0]       activeChQ;
  logic [CHANNELS-1:0] trEnableQ;
  logic [CHANNELS-1:0] rcvEnableQ;
  logic                trAbortQ;
  logic [CHANNELS-1:0] prevBusy;
  logic [CHANNELS-1:0] packetStartQ;
  logic [CHANNELS-1:0] packetEndQ;

  logic [CHANNELS-1:0] selOneHot;
  logic                chSelOk;
  logic                startTx;
  logic                wdFire;
  logic                txDone;
  logic                waitDone;
  logic                cntCanInc;

  // ---------------------------------------------------------------------------
  // Bit-rate clock. io_clk toggles each time the divider wraps; ioUp marks the
  // first clk cycle in which io_clk is high and paces the shared counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt <= '0;
      ioClkQ <= 1'b0;
      ioUp   <= 1'b0;
    end else begin
      ioUp <= 1'b0;
      if (divCnt == DIV_LAST) begin
        divCnt <= '0;
        ioClkQ <= ~ioClkQ;
        ioUp   <= ~ioClkQ;
      end else begin
        divCnt <= divCnt + DIV_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transition conditions.
  // ---------------------------------------------------------------------------
  always_comb begin
    selOneHot = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (CW'(i) == ch_sel) selOneHot[i] = 1'b1;
    end
  end

  assign chSelOk   = (ch_sel < CH_LIMIT);
  assign startTx   = tr_request && (rcv_busy == '0) && chSelOk;
  assign wdFire    = WD_ENABLED && (cnt == TIMEOUT_CNT);
  assign txDone    = !tr_busy && !tr_request;
  assign waitDone  = (cnt == T2R_CNT) || (|rcv_busy);
  assign cntCanInc = ioUp && (cnt != '1);

  // ---------------------------------------------------------------------------
  // Direction FSM. Enables are registered together with the state so that the
  // receiver and transmitter enables can never overlap, even for one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= RECEIVE;
      cnt        <= '0;
      activeChQ  <= '0;
      trEnableQ  <= '0;
      rcvEnableQ <= '1;
      trAbortQ   <= 1'b0;
    end else begin
      trAbortQ <= 1'b0;
      case (stateQ)
        RECEIVE: begin
          cnt <= '0;
          if (startTx) begin
            stateQ     <= TRANSMIT;
            activeChQ  <= ch_sel;
            trEnableQ  <= selOneHot;
            rcvEnableQ <= '0;
          end
        end
        TRANSMIT: begin
          // Watchdog is tested first so a simultaneous normal end still aborts.
          if (wdFire || txDone) begin
            stateQ     <= WAIT;
            cnt        <= '0;
            trAbortQ   <= wdFire;
            trEnableQ  <= '0;
            rcvEnableQ <= '1;
          end else if (cntCanInc) begin
            cnt <= cnt + CNTR_W'(1);
          end
        end
        WAIT: begin
          if (waitDone) begin
            stateQ <= RECEIVE;
            cnt    <= '0;
          end else if (cntCanInc) begin
            cnt <= cnt + CNTR_W'(1);
          end
        end
        default: begin
          stateQ     <= RECEIVE;
          cnt        <= '0;
          trEnableQ  <= '0;
          rcvEnableQ <= '1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-line packet strobes from rcv_busy edges. prevBusy clears on reset, so a
  // line already busy at reset release reports a start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prevBusy     <= '0;
      packetStartQ <= '0;
      packetEndQ   <= '0;
    end else begin
      prevBusy     <= rcv_busy;
      packetStartQ <= rcv_busy & ~prevBusy;
      packetEndQ   <= ~rcv_busy & prevBusy;
    end
  end

  assign rcv_enable   = rcvEnableQ;
  assign tr_enable    = trEnableQ;
  assign io_clk       = ioClkQ;
  assign packet_start = packetStartQ;
  assign packet_end   = packetEndQ;
  assign tr_abort     = trAbortQ;
  assign active_ch    = activeChQ;
  assign state        = stateQ;

endmodule

// File: tb/tb_mil_line_director.sv
// Testbench for mil_line_director: a directed phase table, a few hand-written
// sequences, then randomized stimulus against a cycle-level reference model.
module tb_mil_line_director;

  localparam int CH   = 2;
  localparam int DIV  = 4;
  localparam int T2R  = 12;
  localparam int TO   = 20;
  localparam int CW   = 2;
  localparam int CMAX = 1023;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] chSel = '0;
  logic [CH-1:0] rcvBusy = '0;
  logic          trBusy = 1'b0;
  logic          trRequest = 1'b0;

  logic [CH-1:0] aRcvEn, aTrEn, aStart, aEnd;
  logic          aIoClk, aAbort;
  logic [CW-1:0] aActive;
  logic [1:0]    aState;
  logic [CH-1:0] bRcvEn, bTrEn, bStart, bEnd;
  logic          bIoClk, bAbort;
  logic [CW-1:0] bActive;
  logic [1:0]    bState;

  mil_line_director #(
    .CHANNELS(CH), .IOCLK_DIV(DIV), .T2R_DELAY(T2R), .TR_TIMEOUT(TO), .CNTR_W(10)
  ) dutA (
    .clk(clk), .rst(rst), .ch_sel(chSel), .rcv_busy(rcvBusy), .tr_busy(trBusy),
    .tr_request(trRequest), .rcv_enable(aRcvEn), .tr_enable(aTrEn), .io_clk(aIoClk),
    .packet_start(aStart), .packet_end(aEnd), .tr_abort(aAbort), .active_ch(aActive),
    .state(aState)
  );

  // Same configuration with the watchdog disabled.
  mil_line_director #(
    .CHANNELS(CH), .IOCLK_DIV(DIV), .T2R_DELAY(T2R), .TR_TIMEOUT(0), .CNTR_W(10)
  ) dutB (
    .clk(clk), .rst(rst), .ch_sel(chSel), .rcv_busy(rcvBusy), .tr_busy(trBusy),
    .tr_request(trRequest), .rcv_enable(bRcvEn), .tr_enable(bTrEn), .io_clk(bIoClk),
    .packet_start(bStart), .packet_end(bEnd), .tr_abort(bAbort), .active_ch(bActive),
    .state(bState)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int abortA = 0, abortB = 0, start0 = 0, end0 = 0;

  // Reference model: elapsed clk count since reset gives io_clk and io rises
  // arithmetically; the direction state is tracked with plain integers.
  int         mN = 0, mState = 0, mCnt = 0, mActive = 0;
  logic [1:0] mPrev = '0, mStart = '0, mEnd = '0;
  logic       mAbort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic modelStep();
    bit up;
    if (rst) begin
      mN = 0; mState = 0; mCnt = 0; mActive = 0;
      mPrev = '0; mStart = '0; mEnd = '0; mAbort = 1'b0;
      return;
    end
    up = (mN % (2 * DIV)) == DIV;
    mN++;
    mStart = rcvBusy & ~mPrev;
    mEnd   = ~rcvBusy & mPrev;
    mPrev  = rcvBusy;
    mAbort = 1'b0;
    case (mState)
      0: begin
        mCnt = 0;
        if (trRequest && rcvBusy == 0 && int'(chSel) < CH) begin
          mState = 1;
          mActive = int'(chSel);
        end
      end
      1: begin
        if (TO != 0 && mCnt == TO) begin
          mState = 2; mCnt = 0; mAbort = 1'b1;
        end else if (!trBusy && !trRequest) begin
          mState = 2; mCnt = 0;
        end else if (up && mCnt < CMAX) mCnt++;
      end
      default: begin
        if (mCnt == T2R || rcvBusy != 0) begin
          mState = 0; mCnt = 0;
        end else if (up && mCnt < CMAX) mCnt++;
      end
    endcase
  endtask

  task automatic tick();
    logic [1:0] expTr, expRcv;
    logic       expIo;
    @(posedge clk);
    modelStep();
    #1;
    expTr  = (mState == 1) ? 2'(1 << mActive) : 2'b00;
    expRcv = (mState == 1) ? 2'b00 : 2'b11;
    expIo  = ((mN / DIV) % 2) == 1;
    check("model dutA {state,tr_en,rcv_en,io_clk,start,end,abort,active}",
          32'({aState, aTrEn, aRcvEn, aIoClk, aStart, aEnd, aAbort, aActive}),
          32'({2'(mState), expTr, expRcv, expIo, mStart, mEnd, mAbort, 2'(mActive)}));
    check("model dutB {io_clk,start,end,enables_overlap,active_in_range}",
          32'({bIoClk, bStart, bEnd, (|bTrEn) && (|bRcvEn), bActive < 2'(CH)}),
          32'({expIo, mStart, mEnd, 1'b0, 1'b1}));
    abortA += int'(aAbort);
    abortB += int'(bAbort);
    start0 += int'(aStart[0]);
    end0   += int'(aEnd[0]);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] chSel;
    logic [1:0] rcvBusy;
    logic       trBusy;
    logic       trReq;
    int         cycles;
    logic [1:0] expState;
    logic [1:0] expTrEn;
    logic [1:0] expRcvEn;
    logic [1:0] expStateB;
  } vecT;

  vecT vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int len;
    vecs[0]  = '{1'b1, 2'd0, 2'b00, 1'b0, 1'b0,   2, 2'd0, 2'b00, 2'b11, 2'd0};
    vecs[1]  = '{1'b0, 2'd0, 2'b00, 1'b0, 1'b0,  10, 2'd0, 2'b00, 2'b11, 2'd0};
    vecs[2]  = '{1'b0, 2'd1, 2'b00, 1'b1, 1'b1,   2, 2'd1, 2'b10, 2'b00, 2'd1};
    vecs[3]  = '{1'b0, 2'd1, 2'b00, 1'b1, 1'b0,  16, 2'd1, 2'b10, 2'b00, 2'd1};
    vecs[4]  = '{1'b0, 2'd1, 2'b00, 1'b0, 1'b0,   2, 2'd2, 2'b00, 2'b11, 2'd2};
    vecs[5]  = '{1'b0, 2'd1, 2'b00, 1'b0, 1'b0,  72, 2'd2, 2'b00, 2'b11, 2'd2};
    vecs[6]  = '{1'b0, 2'd1, 2'b00, 1'b0, 1'b0,  40, 2'd0, 2'b00, 2'b11, 2'd0};
    vecs[7]  = '{1'b0, 2'd3, 2'b00, 1'b0, 1'b1,  30, 2'd0, 2'b00, 2'b11, 2'd0};
    vecs[8]  = '{1'b0, 2'd0, 2'b10, 1'b0, 1'b1,  20, 2'd0, 2'b00, 2'b11, 2'd0};
    vecs[9]  = '{1'b0, 2'd0, 2'b00, 1'b0, 1'b1,   2, 2'd1, 2'b01, 2'b00, 2'd1};
    vecs[10] = '{1'b0, 2'd0, 2'b00, 1'b0, 1'b1, 150, 2'd1, 2'b01, 2'b00, 2'd1};
    vecs[11] = '{1'b0, 2'd0, 2'b00, 1'b0, 1'b1,  30, 2'd2, 2'b00, 2'b11, 2'd1};
    vecs[12] = '{1'b0, 2'd0, 2'b01, 1'b0, 1'b1,   2, 2'd0, 2'b00, 2'b11, 2'd1};
    vecs[13] = '{1'b0, 2'd0, 2'b00, 1'b0, 1'b0,   4, 2'd0, 2'b00, 2'b11, 2'd2};

    // Directed phase table.
    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; chSel = vecs[i].chSel; rcvBusy = vecs[i].rcvBusy;
      trBusy = vecs[i].trBusy; trRequest = vecs[i].trReq;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d {stateA,tr_en,rcv_en,stateB}", i),
            32'({aState, aTrEn, aRcvEn, bState}),
            32'({vecs[i].expState, vecs[i].expTrEn, vecs[i].expRcvEn, vecs[i].expStateB}));
    end
    check("watchdog abort pulses dutA", 32'(abortA), 32'd1);
    check("watchdog abort pulses dutB", 32'(abortB), 32'd0);
    check("packet_start[0] pulses", 32'(start0), 32'd1);
    check("packet_end[0] pulses", 32'(end0), 32'd1);

    // Divider: first rise DIV clocks after reset release, then period 2*DIV.
    rst = 1'b1; chSel = '0; rcvBusy = '0; trBusy = 1'b0; trRequest = 1'b0;
    tick();
    rst = 1'b0;
    k = 0;
    do begin tick(); k++; end while (aIoClk !== 1'b1 && k < 20);
    check("io_clk first rise (clk)", 32'(k), 32'(DIV));
    k = 0;
    do begin tick(); k++; end while (aIoClk !== 1'b0 && k < 20);
    do begin tick(); k++; end while (aIoClk !== 1'b1 && k < 40);
    check("io_clk period (clk)", 32'(k), 32'(2 * DIV));

    // Reset in the middle of a transmit.
    chSel = 2'd1; trRequest = 1'b1; trBusy = 1'b1;
    repeat (3) tick();
    check("pre-reset state", 32'(aState), 32'd1);
    rst = 1'b1;
    tick();
    check("reset mid-TRANSMIT {state,tr_en,rcv_en,io_clk,abort,start,end}",
          32'({aState, aTrEn, aRcvEn, aIoClk, aAbort, aStart, aEnd}),
          32'({2'd0, 2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00}));
    rst = 1'b0; trRequest = 1'b0; trBusy = 1'b0; chSel = '0;

    // Randomized segments checked against the model every cycle.
    for (int seg = 0; seg < 220; seg++) begin
      rst       = ($urandom_range(0, 59) == 0);
      chSel     = 2'($urandom_range(0, 3));
      rcvBusy   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      trBusy    = 1'($urandom_range(0, 1));
      trRequest = 1'($urandom_range(0, 1));
      len = rst ? 1 : int'($urandom_range(1, 40));
      repeat (len) tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
